// File: rtl/exu_lsu.sv
// exu_lsu: load/store stage after the ALU; one 32-bit memory op in flight, aligned/extended writeback
module exu_lsu #(
    parameter int          RD_W     = 5,
    parameter logic [31:0] INIT_OUT = '0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_val,
    input  logic [31:0]     in_wdata,
    input  logic            in_ren,
    input  logic            in_wen,
    input  logic [2:0]      in_funct3,
    input  logic [RD_W-1:0] in_rd,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic            mem_we,
    output logic [31:0]     mem_addr,
    output logic [31:0]     mem_wdata,
    output logic [3:0]      mem_wstrb,
    input  logic            mem_rsp_valid,
    input  logic [31:0]     mem_rdata,
    input  logic            mem_rsp_err,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_data,
    output logic [RD_W-1:0] out_rd,
    output logic            out_err
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    state_t state, state_nxt;
    logic [2:0] f3;
    logic [1:0] off;
    logic mem_op, ill, mis, bad, accept;
    logic [31:0] wdata_nxt, s, load_val;
    logic [3:0] strb_nxt;
    assign accept = in_ready && in_valid;
    assign in_ready = state == IDLE && !reset;
    assign mem_req_valid = state == REQ;
    assign out_valid = state == DONE;
    assign mem_op = in_ren | in_wen;
    assign ill = in_wen ? in_funct3 > 3'b010
                        : !(in_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    assign mis = (in_funct3[1:0] == 2'b01 && in_val[0]) || (in_funct3 == 3'b010 && in_val[1:0] != 2'b00);
    assign bad = mem_op && ((in_ren && in_wen) || ill || mis);
    assign strb_nxt = in_funct3[1:0] == 2'b00 ? 4'b0001 << in_val[1:0]
                    : in_funct3[1:0] == 2'b01 ? 4'b0011 << in_val[1:0] : 4'b1111;
    assign wdata_nxt = in_funct3[1:0] == 2'b00 ? {4{in_wdata[7:0]}}
                     : in_funct3[1:0] == 2'b01 ? {2{in_wdata[15:0]}} : in_wdata;
    assign s = mem_rdata >> {off, 3'b000};
    assign load_val = f3 == 3'b000 ? {{24{s[7]}}, s[7:0]}
                    : f3 == 3'b001 ? {{16{s[15]}}, s[15:0]}
                    : f3 == 3'b100 ? {24'd0, s[7:0]}
                    : f3 == 3'b101 ? {16'd0, s[15:0]} : s;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: state_nxt = in_valid ? (mem_op && !bad ? REQ : DONE) : IDLE;
            REQ:  state_nxt = mem_req_ready ? WAIT : REQ;
            WAIT: state_nxt = mem_rsp_valid ? DONE : WAIT;
            DONE: state_nxt = out_ready ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else state <= state_nxt;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            f3 <= '0;
            off <= '0;
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            out_data <= INIT_OUT;
            out_rd <= '0;
            out_err <= 1'b0;
        end else begin
            if (accept) begin
                f3 <= in_funct3;
                off <= in_val[1:0];
                mem_we <= in_wen;
                mem_addr <= {in_val[31:2], 2'b00};
                mem_wdata <= wdata_nxt;
                mem_wstrb <= in_wen ? strb_nxt : 4'b0000;
                out_data <= mem_op ? 32'd0 : in_val;
                out_rd <= in_rd;
                out_err <= bad;
            end
            // stores and bus errors complete with zero data
            if (state == WAIT && mem_rsp_valid) begin
                out_err <= mem_rsp_err;
                out_data <= (mem_rsp_err || mem_we) ? 32'd0 : load_val;
            end
        end
    end
endmodule
